traffic_lane_sensor: RTL and testbench
======================================

Name: traffic_lane_sensor

Overview:
- Models the two street approaches that feed trafficLightSystem.
- Takes car-arrival pulses for street A and street B and counts queued cars per street. A car departs only while that street's light is green.
- Drives the controller's sensor inputs sA/sB: high while cars are waiting.
- Also watches the light outputs for illegal combinations, giving the bench a closed-loop stimulus source and safety monitor.

Parameters:
- QW, 3, width of each queue counter; maximum queue depth is 2**QW-1 (7).
- PASS_CYCLES, 2, consecutive green cycles needed for one queued car to depart (range 1..15).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- arrA  input  1  high during a clk edge = one car arrives on street A.
- arrB  input  1  high during a clk edge = one car arrives on street B.
- lA  input  2  street A light from controller: 00 red, 01 yellow, 10 green, 11 illegal.
- lB  input  2  street B light, same encoding as lA.
- sA  output  1  street A traffic sensor, high when qA != 0.
- sB  output  1  street B traffic sensor, high when qB != 0.
- qA  output  QW  cars queued on street A.
- qB  output  QW  cars queued on street B.
- ovfA  output  1  sticky: a street A arrival was dropped at full queue.
- ovfB  output  1  sticky: a street B arrival was dropped at full queue.
- conflict  output  1  sticky: illegal light state seen.

Behaviour:
- Reset (reset=0, asynchronous, any time including mid-departure) clears all of the following immediately: qA, qB, both pass timers, ovfA, ovfB, conflict. sA=sB=0. Outputs stay cleared until the first rising edge after reset returns to 1.
- Lanes A and B are identical and independent. Each lane has:
  - queue counter q (QW bits);
  - pass timer t (4 bits, counts 0..PASS_CYCLES-1).
- Departure event on a lane, evaluated at each rising edge:
  - If light==10 and q!=0: when t==PASS_CYCLES-1, dep=1 and t->0; otherwise t increments.
  - If light!=10 or q==0: t->0 and dep=0. A partially passed car is abandoned and needs a full PASS_CYCLES of green again.
- Queue update at each edge:
  - arr=1, dep=0: q+1 if q<max. If q==max, q holds and ovf sets.
  - arr=0, dep=1: q-1.
  - arr=1, dep=1: q unchanged, no overflow even at max.
  - arr=0, dep=0: q holds.
- q never wraps in either direction.
- Sensor outputs:
  - sA = (qA!=0) and sB = (qB!=0), combinational from the registered counts.
  - sA rises on the edge that samples the first arrival, so it is visible one cycle after arrA is applied.
- Conflict monitor, checked at each edge: conflict sets and stays set until reset if any of these hold:
  - lA==11;
  - lB==11;
  - lA==10 and lB==10;
  - lA==10 and lB==01;
  - lA==01 and lB==10.
- Conflict has no effect on queue operation.
- Latency:
  - arrival to q/s update: 1 edge;
  - green start to first departure: PASS_CYCLES edges;
  - back-to-back departures: every PASS_CYCLES edges while green and q!=0.
- Output flags ovfA, ovfB and conflict are registered, with no combinational path from any input.

Test Plan:
- Reset then arrA=1 for 3 edges with lA=00 (red) -> qA=3, sA=1 after the first edge; qB=0, sB=0; no flags.
- qA=3, lA=10 held 6 edges, PASS_CYCLES=2, arrA=0 -> qA goes 3,3,2,2,1,1,0 at successive edges; sA falls when qA reaches 0; the timer stops once qA=0.
- qA=2, lA=10 for 1 edge then 01 (yellow) for 1 edge then 10 for 2 edges -> the first partial pass is abandoned; qA=1 only after the 2nd consecutive green edge.
- arrB=1 for 9 edges with lB=00 -> qB saturates at 7 and ovfB=1 after edge 8. Then lB=10 with arrB=1 -> qB stays 7 and ovfB stays 1. Then arrB=0 -> qB drains 7->0.
- Drive lA=10, lB=01 for one edge, then legal 10/00 -> conflict=1 and stays 1. Assert reset=0 mid-cycle -> conflict, qA, qB and all flags clear immediately, without waiting for a clk edge.
- Closed loop with trafficLightSystem, arrA pulse then arrB pulses -> sB=1 eventually gives lB=10 and qB drains to 0; conflict stays 0 throughout.

Source files
------------

// File: rtl/traffic_lane_sensor_if.sv
// Bundle between the lane sensor and whatever drives the lights and arrivals.
//   arrA/arrB : car-arrival pulses, one car per clk edge sampled high
//   lA/lB     : light states per street (00 red, 01 yellow, 10 green, 11 illegal)
//   sA/sB     : traffic sensors, high while that street has queued cars
//   qA/qB     : queued car counts
//   ovfA/ovfB : sticky overflow flags (arrival dropped at full queue)
//   conflict  : sticky illegal-light-combination flag
interface traffic_lane_sensor_if #(
  parameter int unsigned QW = 3
);
  logic          arrA;
  logic          arrB;
  logic [1:0]    lA;
  logic [1:0]    lB;
  logic          sA;
  logic          sB;
  logic [QW-1:0] qA;
  logic [QW-1:0] qB;
  logic          ovfA;
  logic          ovfB;
  logic          conflict;

  // Stimulus / light-controller side
  modport master (
    output arrA, arrB, lA, lB,
    input  sA, sB, qA, qB, ovfA, ovfB, conflict
  );

  // Sensor side
  modport slave (
    input  arrA, arrB, lA, lB,
    output sA, sB, qA, qB, ovfA, ovfB, conflict
  );
endinterface

// File: rtl/traffic_lane_sensor.sv
// Two-street approach model: queues arriving cars per street, lets one car
// depart after PASS_CYCLES consecutive green edges, drives the sensor
// inputs of the light controller and flags illegal light combinations.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : traffic_lane_sensor_if slave modport (arrivals/lights in,
//           sensors/counts/flags out)
module traffic_lane_sensor #(
  parameter int unsigned QW          = 3,
  parameter int unsigned PASS_CYCLES = 2
) (
  input logic                  clk,
  input logic                  reset,
  traffic_lane_sensor_if.slave bus
);
  localparam int unsigned TW    = 4;
  localparam int unsigned LANES = 2;

  localparam logic [QW-1:0] Q_MAX  = {QW{1'b1}};
  localparam logic [QW-1:0] Q_ONE  = QW'(1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [TW-1:0] T_LAST = TW'(PASS_CYCLES - 1);

  localparam logic [1:0] L_YEL = 2'b01;
  localparam logic [1:0] L_GRN = 2'b10;
  localparam logic [1:0] L_BAD = 2'b11;

  // Lane 0 is street A, lane 1 is street B
  logic [LANES-1:0]         arr;
  logic [LANES-1:0][1:0]    light;
  logic [LANES-1:0][QW-1:0] q_r;
  logic [LANES-1:0][QW-1:0] q_nx;
  logic [LANES-1:0][TW-1:0] t_r;
  logic [LANES-1:0][TW-1:0] t_nx;
  logic [LANES-1:0]         ovf_r;
  logic [LANES-1:0]         ovf_nx;
  logic [LANES-1:0]         dep;
  logic                     conflict_r;
  logic                     conflict_nx;

  assign arr   = {bus.arrB, bus.arrA};
  assign light = {bus.lB, bus.lA};

  // Per-lane pass timer, departure and saturating queue update
  always_comb begin
    q_nx   = q_r;
    t_nx   = '0;
    ovf_nx = ovf_r;
    dep    = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      // Any break in green (or an empty queue) abandons a partial pass
      if (light[i] == L_GRN && q_r[i] != '0) begin
        if (t_r[i] == T_LAST) begin
          dep[i] = 1'b1;
        end else begin
          t_nx[i] = t_r[i] + T_ONE;
        end
      end
      case ({arr[i], dep[i]})
        2'b10: begin
          if (q_r[i] == Q_MAX) begin
            ovf_nx[i] = 1'b1;
          end else begin
            q_nx[i] = q_r[i] + Q_ONE;
          end
        end
        2'b01:   q_nx[i] = q_r[i] - Q_ONE;
        default: q_nx[i] = q_r[i];
      endcase
    end
  end

  // Illegal: any 11, or both streets moving unless both are only yellow
  always_comb begin
    conflict_nx = conflict_r;
    if (bus.lA == L_BAD || bus.lB == L_BAD ||
        (bus.lA == L_GRN && bus.lB == L_GRN) ||
        (bus.lA == L_GRN && bus.lB == L_YEL) ||
        (bus.lA == L_YEL && bus.lB == L_GRN)) begin
      conflict_nx = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r        <= '0;
      t_r        <= '0;
      ovf_r      <= '0;
      conflict_r <= 1'b0;
    end else begin
      q_r        <= q_nx;
      t_r        <= t_nx;
      ovf_r      <= ovf_nx;
      conflict_r <= conflict_nx;
    end
  end

  // Sensors decode the registered counts; flags come straight from flops
  assign bus.qA       = q_r[0];
  assign bus.qB       = q_r[1];
  assign bus.sA       = (q_r[0] != '0);
  assign bus.sB       = (q_r[1] != '0);
  assign bus.ovfA     = ovf_r[0];
  assign bus.ovfB     = ovf_r[1];
  assign bus.conflict = conflict_r;
endmodule

// File: tb/tb_traffic_lane_sensor.sv
// Directed bench for traffic_lane_sensor: a queue/green-run model checked
// every negedge, plus literal expectations at key points of each scenario.
module tb_traffic_lane_sensor;
  localparam int QW   = 3;
  localparam int PASS = 2;
  localparam int QMAX = (1 << QW) - 1;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  bit   cmp_en = 1'b0;

  traffic_lane_sensor_if #(.QW(QW)) bus ();

  traffic_lane_sensor #(.QW(QW), .PASS_CYCLES(PASS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: queue length, consecutive productive green edges, sticky flags
  int mq[2];
  int mrun[2];
  bit movf[2];
  bit mconf;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        mq[i] = 0; mrun[i] = 0; movf[i] = 1'b0;
      end
      mconf = 1'b0;
    end else begin
      logic [1:0] lt;
      bit a, leaving, move_a, move_b;
      for (int i = 0; i < 2; i++) begin
        lt = (i == 0) ? bus.lA : bus.lB;
        a  = (i == 0) ? bus.arrA : bus.arrB;
        leaving = 1'b0;
        if (lt == 2'b10 && mq[i] > 0) begin
          mrun[i]++;
          if (mrun[i] == PASS) begin
            leaving = 1'b1;
            mrun[i] = 0;
          end
        end else begin
          mrun[i] = 0;
        end
        if (a && !leaving) begin
          if (mq[i] == QMAX) movf[i] = 1'b1;
          else mq[i]++;
        end else if (!a && leaving) begin
          mq[i]--;
        end
      end
      move_a = (bus.lA != 2'b00);
      move_b = (bus.lB != 2'b00);
      if (bus.lA == 2'b11 || bus.lB == 2'b11 ||
          (move_a && move_b && !(bus.lA == 2'b01 && bus.lB == 2'b01)))
        mconf = 1'b1;
    end
  end

  // Cycle compare against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_qA", 32'(bus.qA), 32'(mq[0]));
      check("cyc_qB", 32'(bus.qB), 32'(mq[1]));
      check("cyc_sA", 32'(bus.sA), 32'(mq[0] > 0));
      check("cyc_sB", 32'(bus.sB), 32'(mq[1] > 0));
      check("cyc_ovfA", 32'(bus.ovfA), 32'(movf[0]));
      check("cyc_ovfB", 32'(bus.ovfB), 32'(movf[1]));
      check("cyc_conflict", 32'(bus.conflict), 32'(mconf));
    end
  end

  task automatic step(input logic aa, input logic ab, input logic [1:0] la, input logic [1:0] lb);
    bus.arrA = aa;
    bus.arrB = ab;
    bus.lA   = la;
    bus.lB   = lb;
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int exp_a[6];
    int bound;
    exp_a = '{3, 2, 2, 1, 1, 0};
    bus.arrA = 1'b0; bus.arrB = 1'b0; bus.lA = 2'b00; bus.lB = 2'b00;
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    cmp_en = 1'b1;
    check("rst_qA", 32'(bus.qA), 0);
    check("rst_sA", 32'(bus.sA), 0);
    check("rst_conflict", 32'(bus.conflict), 0);
    repeat (2) @(negedge clk);
    release_reset();

    // Three arrivals on A during red
    step(1, 0, 2'b00, 2'b00);
    check("arr1_qA", 32'(bus.qA), 1);
    check("arr1_sA", 32'(bus.sA), 1);
    step(1, 0, 2'b00, 2'b00);
    step(1, 0, 2'b00, 2'b00);
    check("arr3_qA", 32'(bus.qA), 3);
    check("arr3_qB", 32'(bus.qB), 0);
    check("arr3_sB", 32'(bus.sB), 0);
    check("arr3_ovfA", 32'(bus.ovfA), 0);

    // Drain A on green, one car every PASS edges
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 2'b10, 2'b00);
      check("drainA_qA", 32'(bus.qA), 32'(exp_a[k]));
    end
    check("drainA_sA", 32'(bus.sA), 0);
    step(0, 0, 2'b10, 2'b00);
    check("idle_green_qA", 32'(bus.qA), 0);

    // Interrupted green abandons the partial pass
    step(1, 0, 2'b00, 2'b00);
    step(1, 0, 2'b00, 2'b00);
    step(0, 0, 2'b10, 2'b00);
    check("part_g1", 32'(bus.qA), 2);
    step(0, 0, 2'b01, 2'b00);
    check("part_y", 32'(bus.qA), 2);
    step(0, 0, 2'b10, 2'b00);
    check("part_g2", 32'(bus.qA), 2);
    step(0, 0, 2'b10, 2'b00);
    check("part_g3", 32'(bus.qA), 1);
    step(0, 0, 2'b10, 2'b00);
    step(0, 0, 2'b10, 2'b00);
    check("part_done", 32'(bus.qA), 0);

    // B saturation and overflow
    for (int k = 1; k <= 9; k++) begin
      step(0, 1, 2'b00, 2'b00);
      if (k == 7) begin
        check("satB7_qB", 32'(bus.qB), 7);
        check("satB7_ovfB", 32'(bus.ovfB), 0);
      end
      if (k == 8) check("satB8_ovfB", 32'(bus.ovfB), 1);
    end
    check("satB9_qB", 32'(bus.qB), 7);
    for (int k = 0; k < 4; k++) step(0, 1, 2'b00, 2'b10);
    check("fullarrdep_qB", 32'(bus.qB), 7);
    check("fullarrdep_ovfB", 32'(bus.ovfB), 1);
    for (int k = 0; k < 14; k++) step(0, 0, 2'b00, 2'b10);
    check("drainB_qB", 32'(bus.qB), 0);
    check("drainB_sB", 32'(bus.sB), 0);
    check("drainB_ovfA", 32'(bus.ovfA), 0);

    // Both-yellow is legal, green/yellow is not
    step(0, 0, 2'b01, 2'b01);
    check("yy_conflict", 32'(bus.conflict), 0);
    step(1, 1, 2'b00, 2'b00);
    step(0, 0, 2'b10, 2'b01);
    check("gy_conflict", 32'(bus.conflict), 1);
    step(0, 0, 2'b10, 2'b00);
    step(0, 0, 2'b10, 2'b00);
    check("sticky_conflict", 32'(bus.conflict), 1);
    check("pre_rst_qB", 32'(bus.qB), 1);

    // Mid-cycle asynchronous reset
    #2 reset = 1'b0;
    #1;
    check("async_conflict", 32'(bus.conflict), 0);
    check("async_qB", 32'(bus.qB), 0);
    check("async_sB", 32'(bus.sB), 0);
    check("async_ovfB", 32'(bus.ovfB), 0);
    repeat (2) @(negedge clk);
    release_reset();

    // Closed loop with a simple bench-side light controller
    step(1, 0, 2'b10, 2'b00);
    for (int k = 0; k < 3; k++) step(0, 1, 2'b10, 2'b00);
    check("loop_qB", 32'(bus.qB), 3);
    check("loop_qA", 32'(bus.qA), 0);
    step(0, 0, 2'b01, 2'b00);
    step(0, 0, 2'b00, 2'b00);
    bound = 0;
    while (bus.sB && bound < 20) begin
      step(0, 0, 2'b00, 2'b10);
      bound++;
    end
    check("loop_bound", 32'(bound < 20), 1);
    check("loop_drained", 32'(bus.qB), 0);
    check("loop_conflict", 32'(bus.conflict), 0);
    step(0, 0, 2'b00, 2'b00);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
